// File: rtl/aes_key_expander.sv
// aes_key_expander
//   Sequential AES-128 key schedule. A cipher key accepted in IDLE is
//   expanded into round keys 0..10. Each round key is presented for exactly
//   one cycle with rk_valid. A single S-box is shared across the four
//   SubWord bytes.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     begin expansion of key_in (sampled only in IDLE)
//   key_in    [0:127] cipher key, bit 0 = MSB, w0 = key_in[0:31]
//   busy      high while an expansion is in progress
//   rk_valid  one-cycle strobe qualifying rk / rk_round
//   rk_round  [3:0] index of the round key on rk
//   rk        [0:127] round key {w0,w1,w2,w3}
//   done      one-cycle strobe coincident with the final rk_valid
module aes_key_expander #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [0:127] rk,
    output logic         done
);

    localparam logic [0:2047] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SUB  = 2'd2,
        MIX  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [0:127]   words_q, words_d;
    logic [0:31]    temp_q, temp_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [3:0]     round_q, round_d;
    logic           rk_valid_q, rk_valid_d;
    logic           done_q, done_d;

    logic [1:0]     rot_idx;
    logic [7:0]     sub_byte;
    logic [7:0]     sbox_out;
    logic [0:31]    t_word;
    logic [0:31]    w0_new, w1_new, w2_new, w3_new;

    // RotWord(w3) byte i is w3 byte (i+1) mod 4; w3 occupies words_q[96:127].
    assign rot_idx  = cnt_q + 2'd1;
    assign sub_byte = words_q[{2'b11, rot_idx, 3'b000} +: 8];
    assign sbox_out = SBOX[{sub_byte, 3'b000} +: 8];

    assign t_word = temp_q ^ {rcon_q, 24'h000000};
    assign w0_new = words_q[0:31]   ^ t_word;
    assign w1_new = words_q[32:63]  ^ w0_new;
    assign w2_new = words_q[64:95]  ^ w1_new;
    assign w3_new = words_q[96:127] ^ w2_new;

    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        temp_d     = temp_q;
        cnt_d      = cnt_q;
        rcon_d     = rcon_q;
        round_d    = round_q;
        rk_valid_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // done_q marks the completion cycle, in which start is ignored.
                if (start && !done_q) begin
                    words_d    = key_in;
                    rcon_d     = 8'h01;
                    round_d    = 4'd0;
                    cnt_d      = 2'd0;
                    rk_valid_d = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                // The LOAD cycle also feeds byte 0 through the S-box, so the
                // first round lands on the same 5-cycle cadence as the others.
                temp_d[0:7] = sbox_out;
                cnt_d       = 2'd1;
                state_d     = SUB;
            end
            SUB: begin
                temp_d[{cnt_q, 3'b000} +: 8] = sbox_out;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = MIX;
                end
            end
            MIX: begin
                words_d    = {w0_new, w1_new, w2_new, w3_new};
                rcon_d     = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                round_d    = round_q + 4'd1;
                rk_valid_d = 1'b1;
                if (round_q == 4'(NUM_ROUNDS - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = SUB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            words_q    <= '0;
            temp_q     <= '0;
            cnt_q      <= 2'd0;
            rcon_q     <= 8'h01;
            round_q    <= 4'd0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            temp_q     <= temp_d;
            cnt_q      <= cnt_d;
            rcon_q     <= rcon_d;
            round_q    <= round_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
        end
    end

    // busy covers the final strobe cycle, when the FSM is already back in IDLE.
    assign busy     = (state_q != IDLE) || done_q;
    assign rk_valid = rk_valid_q;
    assign rk_round = round_q;
    assign rk       = words_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed testbench for aes_key_expander using FIPS-197 and all-zero key
// vectors. Prints one line per expansion and a final summary.
module tb_aes_key_expander;

    logic         clk;
    logic         rst;
    logic         start;
    logic [0:127] key_in;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [0:127] rk;
    logic         done;

    int checks = 0;
    int errors = 0;

    localparam logic [0:127] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [0:127] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [0:127] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] ZERO_KEY = 128'h0;
    localparam logic [0:127] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [0:127] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [0:127] ALT_KEY  = 128'h00112233445566778899aabbccddeeff;

    aes_key_expander #(.NUM_ROUNDS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_round (rk_round),
        .rk       (rk),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one expansion from IDLE. Start is driven in the current cycle
    // (cycle T); afterwards the task sits in cycle T+c after c ticks.
    task automatic run_expansion(input string tag, input logic [0:127] key,
                                 input logic [0:127] exp_r1, input bit chk_r2,
                                 input logic [0:127] exp_r2, input logic [0:127] exp_r10,
                                 input int repulse_cyc, input bit start_at_done);
        int           strobes;
        logic         exp_valid;
        logic [0:127] exp_rk;
        bit           chk_rk;
        strobes = 0;
        start  = 1'b1;
        key_in = key;
        tick();
        start  = 1'b0;
        key_in = ~key;
        for (int c = 1; c <= 51; c++) begin
            exp_valid = (c % 5 == 1);
            checks++;
            if (rk_valid !== exp_valid) begin
                errors++;
                $display("FAIL %s rk_valid T+%0d: got %b expected %b", tag, c, rk_valid, exp_valid);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy T+%0d: got %b expected 1", tag, c, busy);
            end
            checks++;
            if (done !== (c == 51)) begin
                errors++;
                $display("FAIL %s done T+%0d: got %b expected %b", tag, c, done, (c == 51));
            end
            if (rk_valid === 1'b1) strobes++;
            if (exp_valid) begin
                checks++;
                if (rk_round !== 4'((c - 1) / 5)) begin
                    errors++;
                    $display("FAIL %s rk_round T+%0d: got %0d expected %0d", tag, c, rk_round, (c - 1) / 5);
                end
            end
            chk_rk = 1'b1;
            case (c)
                1:       exp_rk = key;
                6:       exp_rk = exp_r1;
                11:      begin exp_rk = exp_r2; chk_rk = chk_r2; end
                51:      exp_rk = exp_r10;
                default: begin exp_rk = '0; chk_rk = 1'b0; end
            endcase
            if (chk_rk) begin
                checks++;
                if (rk !== exp_rk) begin
                    errors++;
                    $display("FAIL %s rk T+%0d: got %h expected %h", tag, c, rk, exp_rk);
                end
            end
            if (c == repulse_cyc) begin
                start  = 1'b1;
                key_in = ALT_KEY;
            end else if (c == repulse_cyc + 1) begin
                start = 1'b0;
            end
            if (c == 51 && start_at_done) start = 1'b1;
            tick();
        end
        start = 1'b0;
        // Cycle T+52: expansion over, last key held.
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle T+52: got busy=%b rk_valid=%b expected 0 0", tag, busy, rk_valid);
        end
        checks++;
        if (rk !== exp_r10) begin
            errors++;
            $display("FAIL %s rk_hold: got %h expected %h", tag, rk, exp_r10);
        end
        checks++;
        if (strobes != 11) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d expected 11", tag, strobes);
        end
        $display("%s: expansion of %h, %0d strobes, final rk %h", tag, key, strobes, rk);
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 || rk !== 128'h0 || rk_round !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b rk_valid=%b done=%b rk_round=%0d rk=%h expected all 0",
                     busy, rk_valid, done, rk_round, rk);
        end
        $display("test_reset: outputs after reset busy=%b rk_valid=%b rk=%h", busy, rk_valid, rk);
    endtask

    task automatic test_fips_vector();
        // Also holds start in the done cycle, which must be ignored.
        run_expansion("fips", FIPS_KEY, FIPS_R1, 1'b1, FIPS_R2, FIPS_R10, -10, 1'b1);
    endtask

    task automatic test_zero_key();
        run_expansion("zero_key", ZERO_KEY, ZERO_R1, 1'b0, '0, ZERO_R10, -10, 1'b0);
    endtask

    task automatic test_restart_ignored();
        run_expansion("restart_ignored", FIPS_KEY, FIPS_R1, 1'b1, FIPS_R2, FIPS_R10, 20, 1'b0);
    endtask

    task automatic test_reset_abort();
        int strobes;
        strobes = 0;
        start  = 1'b1;
        key_in = FIPS_KEY;
        tick();
        start = 1'b0;
        for (int c = 1; c < 25; c++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_busy: got %b expected 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || rk !== 128'h0 || rk_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b rk_valid=%b done=%b rk=%h expected 0",
                     busy, rk_valid, done, rk);
        end
        for (int c = 0; c < 40; c++) begin
            if (rk_valid === 1'b1) strobes++;
            tick();
        end
        checks++;
        if (strobes != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got strobes=%0d busy=%b expected 0 0", strobes, busy);
        end
        $display("test_reset_abort: %0d strobes after reset", strobes);
        run_expansion("after_abort", FIPS_KEY, FIPS_R1, 1'b1, FIPS_R2, FIPS_R10, -10, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_expansion("b2b_first", FIPS_KEY, FIPS_R1, 1'b1, FIPS_R2, FIPS_R10, -10, 1'b0);
        run_expansion("b2b_second", ZERO_KEY, ZERO_R1, 1'b0, '0, ZERO_R10, -10, 1'b0);
    endtask

    task automatic test_start_in_reset();
        rst    = 1'b1;
        start  = 1'b1;
        key_in = FIPS_KEY;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || rk_valid !== 1'b0 || rk !== 128'h0 || done !== 1'b0) begin
                errors++;
                $display("FAIL start_in_reset cycle %0d: got busy=%b rk_valid=%b rk=%h expected 0",
                         c, busy, rk_valid, rk);
            end
        end
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_in_reset_after: got busy=%b rk_valid=%b expected 0 0", busy, rk_valid);
        end
        $display("test_start_in_reset: busy=%b rk_valid=%b", busy, rk_valid);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_fips_vector();
        tick();
        test_zero_key();
        tick();
        test_restart_ignored();
        tick();
        test_reset_abort();
        tick();
        test_back_to_back();
        tick();
        test_start_in_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
